// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the host-side CPU run controller and the CPU state control block.
package cpu_ctrl_pkg;
  localparam int DATA_W       = 8;
  localparam int DEF_NUM_REGS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DREQ  = 3'd3,
    ST_DWAIT = 3'd4,
    ST_DOUT  = 3'd5,
    ST_FIN   = 3'd6
  } state_t;
endpackage

// File: rtl/cpu_wdog.sv
// Watchdog down-counter: reloads to all-ones on clr, counts down while en, flags expiry on
// the (2^WDOG_W-1)th enabled cycle.
module cpu_wdog #(
  parameter int WDOG_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [WDOG_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '1;
    else if (clr)              cnt <= '1;
    else if (en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign expired = en && (cnt == WDOG_W'(1));
endmodule

// File: rtl/cpu_run_ctrl.sv
// Host-side sequencer: streams a program into IM, runs the core under a watchdog, then
// dumps RF registers followed by a DM window one byte per handshake.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int PROG_MAX = 256,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int WDOG_W   = 16,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] prog_len,
  input  logic [DATA_W-1:0] dm_base,
  input  logic [DATA_W-1:0] dm_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              timeout,
  output logic              cpu_hold,
  output logic              cpu_load,
  output logic [DATA_W-1:0] cpu_inst,
  output logic [DATA_W-1:0] cpu_addr,
  output logic              cpu_is_reg,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_done
);
  localparam int IDX_W  = $clog2(PROG_MAX);
  localparam int ITEM_W = $clog2(NUM_REGS + 256);
  localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t              state, state_n;
  logic [DATA_W-1:0]   plen_q, base_q, dlen_q;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W:0]      eff_len;
  logic [ITEM_W-1:0]   item, items_tot;
  logic [LAT_W-1:0]    lat_cnt;
  logic                ld_vld;
  logic [DATA_W-1:0]   ld_addr, ld_data;
  logic                accept, last_byte, last_item, lat_done;
  logic                run_done, wd_en, wd_expired;
  logic                rd_is_reg, addr_phase;
  logic [DATA_W-1:0]   rd_addr;

  // prog_len of 0 selects the full program space
  assign eff_len   = (plen_q == '0) ? (IDX_W+1)'(PROG_MAX) : (IDX_W+1)'(plen_q);
  assign last_byte = ({1'b0, idx} == eff_len - 1'b1);
  assign items_tot = ITEM_W'(NUM_REGS) + ITEM_W'(dlen_q);
  assign last_item = (item == items_tot - 1'b1);
  assign lat_done  = (lat_cnt == LAT_W'(RD_LAT - 1));
  assign rd_is_reg = (item < ITEM_W'(NUM_REGS));
  assign rd_addr   = rd_is_reg ? DATA_W'(item)
                               : base_q + DATA_W'(item - ITEM_W'(NUM_REGS));

  // The core stays held while the final IM byte is still being presented
  assign wd_en    = (state == ST_RUN) && !ld_vld;
  assign run_done = wd_en && cpu_done;

  cpu_wdog #(.WDOG_W(WDOG_W)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != ST_RUN),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n    = state;
    in_ready   = (state == ST_LOAD);
    accept     = in_valid && in_ready;
    busy       = (state != ST_IDLE);
    out_valid  = (state == ST_DOUT);
    cpu_load   = (state == ST_LOAD) || ld_vld;
    cpu_hold   = (state != ST_RUN) || ld_vld;
    cpu_inst   = ld_data;
    addr_phase = (state == ST_DREQ) || (state == ST_DWAIT);
    cpu_addr   = ld_vld ? ld_addr : (addr_phase ? rd_addr : '0);
    cpu_is_reg = addr_phase && rd_is_reg;
    case (state)
      ST_IDLE:  if (start) state_n = ST_LOAD;
      ST_LOAD:  if (accept && last_byte) state_n = ST_RUN;
      ST_RUN:   if (run_done || wd_expired) state_n = ST_DREQ;
      ST_DREQ:  state_n = ST_DWAIT;
      ST_DWAIT: if (lat_done) state_n = ST_DOUT;
      ST_DOUT:  if (out_ready) state_n = last_item ? ST_FIN : ST_DREQ;
      ST_FIN:   state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      plen_q   <= '0;
      base_q   <= '0;
      dlen_q   <= '0;
      idx      <= '0;
      item     <= '0;
      lat_cnt  <= '0;
      ld_vld   <= 1'b0;
      ld_addr  <= '0;
      ld_data  <= '0;
      out_data <= '0;
      timeout  <= 1'b0;
    end else begin
      ld_vld  <= accept;
      ld_addr <= accept ? DATA_W'(idx) : '0;
      ld_data <= accept ? in_data : '0;
      if (state == ST_IDLE && start) begin
        plen_q  <= prog_len;
        base_q  <= dm_base;
        dlen_q  <= dm_len;
        idx     <= '0;
        item    <= '0;
        timeout <= 1'b0;
      end
      if (accept) idx <= idx + 1'b1;
      // a done seen in the expiry cycle takes priority over the timeout flag
      if (wd_expired && !run_done) timeout <= 1'b1;
      if (state == ST_DREQ)       lat_cnt <= '0;
      else if (state == ST_DWAIT) lat_cnt <= lat_cnt + 1'b1;
      if (state == ST_DWAIT && lat_done) out_data <= cpu_data;
      if (state == ST_DOUT && out_ready) item <= item + 1'b1;
    end
  end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Table-driven bench for cpu_run_ctrl with a behavioural CPU readback model.
module tb_cpu_run_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] prog_len, dm_base, dm_len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_ready, busy, timeout;
  logic [7:0] out_data;
  logic       cpu_hold, cpu_load, cpu_is_reg, cpu_done;
  logic [7:0] cpu_inst, cpu_addr, cpu_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.WDOG_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .prog_len(prog_len), .dm_base(dm_base),
    .dm_len(dm_len), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy),
    .timeout(timeout), .cpu_hold(cpu_hold), .cpu_load(cpu_load), .cpu_inst(cpu_inst),
    .cpu_addr(cpu_addr), .cpu_is_reg(cpu_is_reg), .cpu_data(cpu_data), .cpu_done(cpu_done)
  );

  // CPU readback model: RF r[i]=i+1, DM[a]=a^5A, one cycle of read latency
  always @(posedge clk) cpu_data <= cpu_is_reg ? cpu_addr + 8'd1 : (cpu_addr ^ 8'h5A);

  typedef struct {
    logic [7:0] plen, base, dlen;
    int         done_at;    // run cycle that raises cpu_done, 0 = never
    int         pct;        // out_ready duty in percent
    logic       exp_to;
    int         exp_run;
    int         exp_items;
    logic [7:0] exp_last;   // last DM address read
    logic       sir;        // pulse start during RUN
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_hold"},  cpu_hold, 1);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_load"},  cpu_load, 0);
    chk({tag, "_inst"},  cpu_inst, 0);
    chk({tag, "_addr"},  cpu_addr, 0);
    chk({tag, "_isreg"}, cpu_is_reg, 0);
    chk({tag, "_rdy"},   in_ready, 0);
    chk({tag, "_ovld"},  out_valid, 0);
    chk({tag, "_odata"}, out_data, 0);
    chk({tag, "_to"},    timeout, 0);
  endtask

  function automatic logic [7:0] exp_addr(input vec_t v, input int it);
    return (it < 8) ? 8'(it) : 8'(v.base + 8'(it - 8));
  endfunction

  task automatic session(input vec_t v);
    int n, i, cyc, rc, it;
    logic pend;
    logic [7:0] paddr, pdata, last_dm;
    @(negedge clk);
    start = 1; prog_len = v.plen; dm_base = v.base; dm_len = v.dlen;
    @(negedge clk);
    start = 0;
    chk("start_busy", busy, 1);
    chk("start_to_clr", timeout, 0);
    n = (v.plen == 0) ? 256 : int'(v.plen);
    i = 0; pend = 0; cyc = 0; paddr = 0; pdata = 0;
    forever begin
      if (pend) begin
        chk("ld_load", cpu_load, 1);
        chk("ld_hold", cpu_hold, 1);
        chk("ld_addr", cpu_addr, paddr);
        chk("ld_inst", cpu_inst, pdata);
      end else if (i < n) begin
        chk("ld_gap_inst", cpu_inst, 0);
      end
      pend = 0;
      if (i >= n || cyc > 3000) break;
      chk("ld_rdy", in_ready, 1);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'hA0 + 8'(i * 17);
      if (in_valid) begin pend = 1; paddr = 8'(i); pdata = in_data; i++; end
      @(negedge clk); cyc++;
    end
    in_valid = 1;  // must be ignored outside LOAD
    chk("ld_count", i, n);
    chk("rdy_drop", in_ready, 0);
    rc = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (cpu_hold) break;
      rc++;
      chk("run_load", cpu_load, 0);
      cpu_done = (rc == v.done_at);
      start    = v.sir && (rc == 3);
      dm_len   = start ? 8'hAA : v.dlen;
    end
    cpu_done = 0; start = 0; in_valid = 0; dm_len = v.dlen;
    chk("run_cycles", rc, v.exp_run);
    chk("run_timeout", timeout, v.exp_to);
    it = 0; cyc = 0; last_dm = 8'h00;
    while (busy && cyc < 4000) begin
      if (out_valid) begin
        chk("out_data", out_data, (it < 8) ? 8'(it + 1) : (exp_addr(v, it) ^ 8'h5A));
        out_ready = ($urandom_range(0, 99) < v.pct);
        if (out_ready) it++;
      end else begin
        out_ready = 0;
        if (it < v.exp_items) begin
          chk("rd_addr", cpu_addr, exp_addr(v, it));
          chk("rd_isreg", cpu_is_reg, (it < 8) ? 1 : 0);
          if (it >= 8) last_dm = cpu_addr;
        end
      end
      @(negedge clk); cyc++;
    end
    out_ready = 0;
    chk("dump_items", it, v.exp_items);
    chk("fin_busy", busy, 0);
    chk("fin_hold", cpu_hold, 1);
    chk("fin_to", timeout, v.exp_to);
    if (v.dlen != 0) chk("last_dm", last_dm, v.exp_last);
  endtask

  initial begin
    vecs[0] = '{8'd4, 8'hF0, 8'd4, 10, 100, 1'b0, 10, 12, 8'hF3, 1'b0};
    vecs[1] = '{8'd3, 8'h10, 8'd2,  0, 100, 1'b1, 15, 10, 8'h11, 1'b0};
    vecs[2] = '{8'd2, 8'hFE, 8'd3,  5, 100, 1'b0,  5, 11, 8'h00, 1'b0};
    vecs[3] = '{8'd6, 8'h40, 8'd5,  7,  30, 1'b0,  7, 13, 8'h44, 1'b1};
    vecs[4] = '{8'd0, 8'h00, 8'd0, 15,  60, 1'b0, 15,  8, 8'h00, 1'b0};
    vecs[5] = '{8'd1, 8'h7F, 8'd1,  1,  50, 1'b0,  1,  9, 8'h7F, 1'b0};

    rst = 0; start = 0; prog_len = 0; dm_base = 0; dm_len = 0;
    in_valid = 0; in_data = 0; out_ready = 0; cpu_done = 0;
    repeat (3) @(negedge clk);
    chk_idle("rst");
    rst = 1;
    @(negedge clk);
    chk_idle("idle");

    for (int k = 0; k < 6; k++) session(vecs[k]);

    // reset while byte 2 of 5 is being presented to IM
    @(negedge clk);
    start = 1; prog_len = 8'd5; dm_base = 0; dm_len = 0;
    @(negedge clk);
    start = 0;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1; in_data = 8'h30 + 8'(b);
      @(negedge clk);
    end
    chk("mid_load_strobe", cpu_addr, 8'd2);
    rst = 0; in_valid = 0;
    #1 chk_idle("rst_load");
    @(negedge clk);
    rst = 1;
    session(vecs[0]);

    // reset while a dump byte is stalled in DOUT
    @(negedge clk);
    start = 1; prog_len = 8'd1; dm_base = 8'h20; dm_len = 8'd2;
    @(negedge clk);
    start = 0; in_valid = 1; in_data = 8'h55;
    @(negedge clk);
    in_valid = 0;
    for (int c = 0; c < 50 && cpu_hold; c++) @(negedge clk);
    cpu_done = 1;
    @(negedge clk);
    cpu_done = 0;
    for (int c = 0; c < 50 && !out_valid; c++) @(negedge clk);
    chk("dout_reached", out_valid, 1);
    chk("dout_r0", out_data, 8'h01);
    repeat (3) @(negedge clk);
    chk("dout_stall", out_data, 8'h01);
    rst = 0;
    #1 chk_idle("rst_dout");
    @(negedge clk);
    rst = 1;
    session(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
